// File: rtl/pcs_10g_block_sync.sv
// -----------------------------------------------------------------------------
// pcs_10g_block_sync
//   RX 66b block-lock synchroniser. Sits between the RX gearbox and the
//   descrambler. It tests each 66b sync header, acquires and loses block lock,
//   requests bit-slips from the gearbox, and forwards only locked blocks.
//
// Ports
//   clk                 in   PCS block clock
//   rst_n               in   asynchronous active-low reset
//   rx_block_in[65:0]   in   block from gearbox, [65:64] = sync header
//   rx_block_valid      in   rx_block_in qualifier
//   rx_block_out[65:0]  out  registered copy of rx_block_in
//   rx_block_out_valid  out  block forwarded while locked
//   block_lock          out  block lock status
//   slip_out            out  one-cycle bit-slip request to gearbox
//   sh_invld_cnt[4:0]   out  invalid-header count in the current window
// -----------------------------------------------------------------------------
module pcs_10g_block_sync #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [65:0] rx_block_in,
    input  logic        rx_block_valid,
    output logic [65:0] rx_block_out,
    output logic        rx_block_out_valid,
    output logic        block_lock,
    output logic        slip_out,
    output logic [4:0]  sh_invld_cnt
);

    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam logic [6:0]    CNT_MAX = 7'(SH_CNT_MAX);
    localparam logic [4:0]    INV_MAX = 5'(SH_INVLD_MAX);
    localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT);

    // The slip itself happens on the edge of the offending block, so there is
    // no resident SLIP state: HUNT/LOCKED jump straight to S_SLIP_WAIT.
    typedef enum logic [1:0] {
        S_HUNT      = 2'd0,
        S_LOCKED    = 2'd1,
        S_SLIP_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    sh_cnt_q, sh_cnt_d;
    logic [4:0]    inv_q, inv_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          lock_q, lock_d;
    logic          slip_q, slip_d;
    logic [65:0]   blk_q;
    logic          ovld_q;

    logic          hdr_ok;
    logic [6:0]    cnt_n;
    logic [4:0]    inv_n;
    logic [WW-1:0] wait_n;

    // 01 and 10 are the only legal sync headers.
    assign hdr_ok = rx_block_in[65] ^ rx_block_in[64];
    assign cnt_n  = sh_cnt_q + 7'd1;
    assign inv_n  = inv_q + {4'd0, ~hdr_ok};
    assign wait_n = wait_q + WW'(1);

    always_comb begin
        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        inv_d    = inv_q;
        wait_d   = wait_q;
        lock_d   = lock_q;
        slip_d   = 1'b0;
        // Idle cycles freeze everything.
        if (rx_block_valid) begin
            unique case (state_q)
                S_HUNT: begin
                    if (!hdr_ok) begin
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        inv_d    = '0;
                        wait_d   = '0;
                        state_d  = S_SLIP_WAIT;
                    end else if (cnt_n == CNT_MAX) begin
                        lock_d   = 1'b1;
                        sh_cnt_d = '0;
                        inv_d    = '0;
                        state_d  = S_LOCKED;
                    end else begin
                        sh_cnt_d = cnt_n;
                    end
                end
                S_LOCKED: begin
                    // Too many bad headers wins over a window ending on the same block.
                    if (inv_n == INV_MAX) begin
                        lock_d   = 1'b0;
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        inv_d    = '0;
                        wait_d   = '0;
                        state_d  = S_SLIP_WAIT;
                    end else if (cnt_n == CNT_MAX) begin
                        sh_cnt_d = '0;
                        inv_d    = '0;
                    end else begin
                        sh_cnt_d = cnt_n;
                        inv_d    = inv_n;
                    end
                end
                S_SLIP_WAIT: begin
                    // Blocks here are untested while the gearbox realigns.
                    if (wait_n == WAIT_MAX) begin
                        wait_d  = '0;
                        state_d = S_HUNT;
                    end else begin
                        wait_d = wait_n;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HUNT;
            sh_cnt_q <= '0;
            inv_q    <= '0;
            wait_q   <= '0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
            blk_q    <= '0;
            ovld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            inv_q    <= inv_d;
            wait_q   <= wait_d;
            lock_q   <= lock_d;
            slip_q   <= slip_d;
            if (rx_block_valid) blk_q <= rx_block_in;
            // Pre-edge lock: the locking block is dropped, the unlocking one is sent.
            ovld_q   <= rx_block_valid & lock_q;
        end
    end

    assign rx_block_out       = blk_q;
    assign rx_block_out_valid = ovld_q;
    assign block_lock         = lock_q;
    assign slip_out           = slip_q;
    assign sh_invld_cnt       = inv_q;

endmodule

// File: tb/tb_pcs_10g_block_sync.sv
module tb_pcs_10g_block_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] rx_block_in = '0;
    logic        rx_block_valid = 1'b0;
    logic [65:0] rx_block_out;
    logic        rx_block_out_valid;
    logic        block_lock;
    logic        slip_out;
    logic [4:0]  sh_invld_cnt;

    int checks = 0;
    int failures = 0;
    logic [65:0] last_blk;

    pcs_10g_block_sync dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_block_in       (rx_block_in),
        .rx_block_valid    (rx_block_valid),
        .rx_block_out      (rx_block_out),
        .rx_block_out_valid(rx_block_out_valid),
        .block_lock        (block_lock),
        .slip_out          (slip_out),
        .sh_invld_cnt      (sh_invld_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic send(input logic [1:0] sh, input logic v);
        rx_block_in    = {sh, $urandom(), $urandom()};
        rx_block_valid = v;
        if (v) last_blk = rx_block_in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_block_valid = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic get_lock();
        do_reset();
        for (int i = 0; i < 64; i++) send(2'b01, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({rx_block_out, rx_block_out_valid, block_lock, slip_out, sh_invld_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {rx_block_out, rx_block_out_valid, block_lock, slip_out, sh_invld_cnt});
        end
    endtask

    task automatic test_lock();
        int slips = 0;
        do_reset();
        for (int i = 0; i < 63; i++) begin
            send(2'b01, 1'b1);
            if (slip_out !== 1'b0) slips++;
        end
        checks++;
        if (block_lock !== 1'b0) begin failures++; $display("FAIL lock_after_63 got=%b exp=0", block_lock); end
        send(2'b10, 1'b1);
        if (slip_out !== 1'b0) slips++;
        checks++;
        if (block_lock !== 1'b1) begin failures++; $display("FAIL lock_after_64 got=%b exp=1", block_lock); end
        checks++;
        if (rx_block_out_valid !== 1'b0) begin failures++; $display("FAIL lock_blk_not_fwd got=%b exp=0", rx_block_out_valid); end
        send(2'b01, 1'b1);
        checks++;
        if (rx_block_out_valid !== 1'b1 || rx_block_out !== last_blk) begin
            failures++;
            $display("FAIL blk65_fwd got=%b/%h exp=1/%h", rx_block_out_valid, rx_block_out, last_blk);
        end
        checks++;
        if (slips !== 0) begin failures++; $display("FAIL t1_no_slip got=%0d exp=0", slips); end
    endtask

    task automatic test_hunt_slip();
        do_reset();
        for (int i = 0; i < 10; i++) send(2'b01, 1'b1);
        send(2'b00, 1'b1);
        checks++;
        if (slip_out !== 1'b1) begin failures++; $display("FAIL hunt_slip got=%b exp=1", slip_out); end
        // Bad header during the wait must be ignored.
        send(2'b11, 1'b1);
        checks++;
        if (slip_out !== 1'b0) begin failures++; $display("FAIL slip_one_cycle got=%b exp=0", slip_out); end
        send(2'b01, 1'b1);
        checks++;
        if (slip_out !== 1'b0) begin failures++; $display("FAIL wait_ignores_bad got=%b exp=0", slip_out); end
        for (int i = 0; i < 63; i++) send(2'b01, 1'b1);
        checks++;
        if (block_lock !== 1'b0) begin failures++; $display("FAIL relock_63 got=%b exp=0", block_lock); end
        send(2'b01, 1'b1);
        checks++;
        if (block_lock !== 1'b1) begin failures++; $display("FAIL relock_64 got=%b exp=1", block_lock); end
    endtask

    task automatic test_window_hold();
        get_lock();
        for (int i = 0; i < 15; i++) send(2'b11, 1'b1);
        checks++;
        if (sh_invld_cnt !== 5'd15 || block_lock !== 1'b1) begin
            failures++;
            $display("FAIL inv15_held got=%0d/%b exp=15/1", sh_invld_cnt, block_lock);
        end
        for (int i = 0; i < 48; i++) send(2'b10, 1'b1);
        checks++;
        if (sh_invld_cnt !== 5'd15) begin failures++; $display("FAIL inv_pre_wrap got=%0d exp=15", sh_invld_cnt); end
        send(2'b10, 1'b1);
        checks++;
        if (sh_invld_cnt !== 5'd0 || block_lock !== 1'b1) begin
            failures++;
            $display("FAIL window_wrap got=%0d/%b exp=0/1", sh_invld_cnt, block_lock);
        end
    endtask

    task automatic test_lock_loss();
        get_lock();
        for (int i = 0; i < 15; i++) send(2'b00, 1'b1);
        checks++;
        if (block_lock !== 1'b1 || slip_out !== 1'b0) begin
            failures++;
            $display("FAIL loss_pre15 got=%b/%b exp=1/0", block_lock, slip_out);
        end
        send(2'b00, 1'b1);
        checks++;
        if (block_lock !== 1'b0 || slip_out !== 1'b1 || sh_invld_cnt !== 5'd0) begin
            failures++;
            $display("FAIL loss_16 got=%b/%b/%0d exp=0/1/0", block_lock, slip_out, sh_invld_cnt);
        end
        checks++;
        if (rx_block_out_valid !== 1'b1) begin failures++; $display("FAIL drop_blk_fwd got=%b exp=1", rx_block_out_valid); end
        send(2'b01, 1'b1);
        checks++;
        if (rx_block_out_valid !== 1'b0 || slip_out !== 1'b0) begin
            failures++;
            $display("FAIL post_loss got=%b/%b exp=0/0", rx_block_out_valid, slip_out);
        end
    endtask

    task automatic test_gaps();
        logic [65:0] held;
        int gap_bad = 0;
        do_reset();
        for (int i = 0; i < 63; i++) begin
            send(2'b01, 1'b1);
            held = last_blk;
            send(2'b00, 1'b0);
            if (rx_block_out !== held || rx_block_out_valid !== 1'b0 || slip_out !== 1'b0) gap_bad++;
        end
        checks++;
        if (gap_bad !== 0) begin failures++; $display("FAIL gap_freeze got=%0d exp=0", gap_bad); end
        checks++;
        if (block_lock !== 1'b0) begin failures++; $display("FAIL gap_lock_63 got=%b exp=0", block_lock); end
        send(2'b01, 1'b1);
        checks++;
        if (block_lock !== 1'b1) begin failures++; $display("FAIL gap_lock_64 got=%b exp=1", block_lock); end
    endtask

    task automatic test_async_reset();
        get_lock();
        for (int i = 0; i < 3; i++) send(2'b11, 1'b1);
        for (int i = 0; i < 5; i++) send(2'b01, 1'b1);
        checks++;
        if (sh_invld_cnt !== 5'd3) begin failures++; $display("FAIL pre_rst_inv got=%0d exp=3", sh_invld_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_block_out, rx_block_out_valid, block_lock, slip_out, sh_invld_cnt} !== '0) begin
            failures++;
            $display("FAIL async_rst got=%h exp=0",
                     {rx_block_out, rx_block_out_valid, block_lock, slip_out, sh_invld_cnt});
        end
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 63; i++) send(2'b01, 1'b1);
        checks++;
        if (block_lock !== 1'b0) begin failures++; $display("FAIL reacq_63 got=%b exp=0", block_lock); end
        send(2'b01, 1'b1);
        checks++;
        if (block_lock !== 1'b1) begin failures++; $display("FAIL reacq_64 got=%b exp=1", block_lock); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        get_lock();
        for (int i = 0; i < 200; i++) begin
            send((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
            if (rx_block_out !== last_blk || rx_block_out_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL passthru got=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hunt_slip();
        test_window_hold();
        test_lock_loss();
        test_gaps();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
